// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: packet request encoding, PIDs, SYNC byte, CRC16 constants and bit timing.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package usb_tx_pkg;

  // Request codes driven by the protocol controller on tx_packet
  typedef enum logic [1:0] {
    PKT_IDLE = 2'b00,
    PKT_DATA = 2'b01,
    PKT_ACK  = 2'b10,
    PKT_NAK  = 2'b11
  } tx_pkt_e;

  // Serialiser segments; the state names the field the next bit comes from
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_PAYLOAD,
    ST_CRC,
    ST_EOP
  } tx_state_e;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam logic [7:0]  PID_ACK     = 8'hD2;
  localparam logic [7:0]  PID_NAK     = 8'h5A;
  localparam logic [7:0]  PID_DATA0   = 8'hC3;
  localparam logic [7:0]  PID_DATA1   = 8'h4B;

  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;

  localparam logic [6:0]  MAX_PAYLOAD = 7'd64;

  // Bit-period pattern {8,8,9} clk; averages the 12 Mb/s bit time on this clock
  localparam logic [3:0]  BIT_LEN_SHORT = 4'd8;
  localparam logic [3:0]  BIT_LEN_LONG  = 4'd9;
  localparam logic [1:0]  LAST_PHASE    = 2'd2;

  // Length in clk of the bit period started in the given phase
  function automatic logic [3:0] bit_len(input logic [1:0] phase);
    return (phase == LAST_PHASE) ? BIT_LEN_LONG : BIT_LEN_SHORT;
  endfunction

  // One serial CRC16 step for a bit taken in send order
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[15];
    return fb ? ({crc[14:0], 1'b0} ^ CRC16_POLY) : {crc[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/usb_crc16_gen.sv
// usb_crc16_gen: serial USB CRC16 over payload bits in send order.
// Latency: crc reflects a shifted bit one clk after shift_en.
// Backpressure: none; shifts only when shift_en is high, holds otherwise.
module usb_crc16_gen
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  // Remainder register: preset on reset/clear, advanced one bit per shift_en
  always_ff @(posedge clk) begin
    if (n_rst || clear) begin
      r_crc <= CRC16_INIT;
    end else if (shift_en) begin
      r_crc <= crc16_step(r_crc, bit_in);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/usb_tx.sv
// usb_tx: full-speed USB transmit encoder (SYNC, PID, payload, CRC16, EOP; LSB-first, bit-stuffed, NRZI).
// Latency: first SYNC bit on the line one clk after the request is latched; tx_done one clk after EOP J ends.
// Backpressure: requests ignored until tx_done; payload pulled one byte per get_tx_packet. Option: USB_TX_PID_TOGGLE_EN.
module usb_tx
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] tx_packet,
  input  logic [6:0] tx_packet_data_size,
  input  logic [7:0] tx_packet_data,
  output logic       dPlus_out,
  output logic       dMinus_out,
  output logic       tx_done,
  output logic       get_tx_packet
);

  tx_state_e   r_state;
  logic [3:0]  r_cnt;         // clk left in the current bit period
  logic [1:0]  r_phase;       // position in the {8,8,9} pattern for the next period
  logic [3:0]  r_idx;         // bit index within the current field
  logic [2:0]  r_ones;        // run of consecutive logical 1s on the wire
  logic        r_level;       // NRZI line level, 1 = J
  logic        r_is_data;
  logic [7:0]  r_pid;
  logic [7:0]  r_byte;
  logic [6:0]  r_bytes_left;
  logic        r_dp;
  logic        r_dm;
  logic        r_done;
  logic        r_get;

  tx_pkt_e     w_pkt;
  logic [6:0]  w_size;
  logic        w_start;
  logic        w_tick;
  logic        w_stuff;
  logic        w_bit;
  logic        w_next_level;
  logic        w_crc_shift;
  logic        w_eop_end;
  logic [7:0]  w_data_pid;
  logic [15:0] w_crc;

  assign w_pkt        = tx_pkt_e'(tx_packet);
  assign w_size       = (tx_packet_data_size > MAX_PAYLOAD) ? MAX_PAYLOAD : tx_packet_data_size;
  // A request held through the tx_done cycle must not restart a packet
  assign w_start      = (r_state == ST_IDLE) && !r_done && (w_pkt != PKT_IDLE);
  assign w_tick       = (r_state != ST_IDLE) && (r_cnt == 4'd0);
  assign w_stuff      = (r_ones == 3'd6);
  assign w_next_level = w_bit ? r_level : ~r_level;
  assign w_crc_shift  = w_tick && !w_stuff && (r_state == ST_PAYLOAD);
  assign w_eop_end    = w_tick && (r_state == ST_EOP) && (r_idx == 4'd3);

`ifdef USB_TX_PID_TOGGLE_EN
  logic r_toggle;

  // Data toggle: flips when a DATA packet completes
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_toggle <= 1'b0;
    end else if (w_eop_end && r_is_data) begin
      r_toggle <= ~r_toggle;
    end
  end

  assign w_data_pid = r_toggle ? PID_DATA1 : PID_DATA0;
`else
  assign w_data_pid = PID_DATA0;
`endif

  // Logical bit the current field would send next (before stuffing)
  always_comb begin
    w_bit = 1'b1;
    case (r_state)
      ST_SYNC:    w_bit = SYNC_BYTE[r_idx[2:0]];
      ST_PID:     w_bit = r_pid[r_idx[2:0]];
      ST_PAYLOAD: w_bit = r_byte[r_idx[2:0]];
      ST_CRC:     w_bit = ~w_crc[4'd15 - r_idx];
      default:    w_bit = 1'b1;
    endcase
  end

  usb_crc16_gen u_crc (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (w_start),
    .shift_en (w_crc_shift),
    .bit_in   (w_bit),
    .crc      (w_crc)
  );

  // Packet FSM, bit timer, stuffer and NRZI driver; all line outputs registered
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_phase      <= 2'd0;
      r_idx        <= 4'd0;
      r_ones       <= 3'd0;
      r_level      <= 1'b1;
      r_is_data    <= 1'b0;
      r_pid        <= 8'd0;
      r_byte       <= 8'd0;
      r_bytes_left <= 7'd0;
      r_dp         <= 1'b1;
      r_dm         <= 1'b0;
      r_done       <= 1'b0;
      r_get        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_get  <= 1'b0;
      // Payload byte is captured the clk after the fetch pulse
      if (r_get) begin
        r_byte <= tx_packet_data;
      end

      if (w_start) begin
        r_state      <= ST_SYNC;
        r_cnt        <= 4'd0;
        r_phase      <= 2'd0;
        r_idx        <= 4'd0;
        r_ones       <= 3'd0;
        r_level      <= 1'b1;
        r_is_data    <= (w_pkt == PKT_DATA);
        r_bytes_left <= w_size;
        case (w_pkt)
          PKT_ACK: r_pid <= PID_ACK;
          PKT_NAK: r_pid <= PID_NAK;
          default: r_pid <= w_data_pid;
        endcase
      end else if (w_tick) begin
        r_cnt   <= bit_len(r_phase) - 4'd1;
        r_phase <= (r_phase == LAST_PHASE) ? 2'd0 : r_phase + 2'd1;

        if (w_stuff) begin
          // Stuffed 0: toggle the line, field position unchanged
          r_ones  <= 3'd0;
          r_level <= ~r_level;
          r_dp    <= ~r_level;
          r_dm    <= r_level;
        end else begin
          case (r_state)
            ST_SYNC, ST_PID, ST_PAYLOAD, ST_CRC: begin
              r_ones  <= w_bit ? r_ones + 3'd1 : 3'd0;
              r_level <= w_next_level;
              r_dp    <= w_next_level;
              r_dm    <= ~w_next_level;
              r_idx   <= r_idx + 4'd1;

              if (r_state == ST_SYNC && r_idx == 4'd7) begin
                r_state <= ST_PID;
                r_idx   <= 4'd0;
              end else if (r_state == ST_PID && r_idx == 4'd7) begin
                r_idx <= 4'd0;
                if (!r_is_data) begin
                  r_state <= ST_EOP;
                end else if (r_bytes_left != 7'd0) begin
                  r_state <= ST_PAYLOAD;
                  r_get   <= 1'b1;
                end else begin
                  r_state <= ST_CRC;
                end
              end else if (r_state == ST_PAYLOAD && r_idx == 4'd7) begin
                r_idx        <= 4'd0;
                r_bytes_left <= r_bytes_left - 7'd1;
                if (r_bytes_left == 7'd1) begin
                  r_state <= ST_CRC;
                end else begin
                  r_get <= 1'b1;
                end
              end else if (r_state == ST_CRC && r_idx == 4'd15) begin
                r_state <= ST_EOP;
                r_idx   <= 4'd0;
              end
            end
            ST_EOP: begin
              r_ones <= 3'd0;
              r_idx  <= r_idx + 4'd1;
              if (r_idx < 4'd2) begin
                // SE0
                r_dp <= 1'b0;
                r_dm <= 1'b0;
              end else if (r_idx == 4'd2) begin
                // Closing J; NRZI reference returns to J
                r_dp    <= 1'b1;
                r_dm    <= 1'b0;
                r_level <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
                r_idx   <= 4'd0;
                r_done  <= 1'b1;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign dPlus_out     = r_dp;
  assign dMinus_out    = r_dm;
  assign tx_done       = r_done;
  assign get_tx_packet = r_get;

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: directed packets checked every clk against a bit-list model of the line.
// The model builds the logical bit stream, stuffs it, NRZI-codes it and expands it to clk.
// Fetch pulses are checked by count and by the bit period they fall in.
module tb_usb_tx;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_data_size;
  logic [7:0] tx_packet_data;
  logic       dPlus_out;
  logic       dMinus_out;
  logic       tx_done;
  logic       get_tx_packet;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pay [0:63];

  // Model state
  logic       s_bits[$];
  int         first_idx[$];
  int         stuff_before[$];
  int         bit_start[$];
  logic [1:0] exp_line[$];
  int         ones;
  int         last_stuff;

  usb_tx dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .tx_packet           (tx_packet),
    .tx_packet_data_size (tx_packet_data_size),
    .tx_packet_data      (tx_packet_data),
    .dPlus_out           (dPlus_out),
    .dMinus_out          (dMinus_out),
    .tx_done             (tx_done),
    .get_tx_packet       (get_tx_packet)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // USB CRC16 remainder over pay[0..n-1], bits LSB first
  function automatic logic [15:0] crc_of(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) begin
        fb = pay[k][j] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  task automatic push_bit(input logic b);
    s_bits.push_back(b);
    last_stuff = 0;
    if (b) ones++;
    else   ones = 0;
    if (ones == 6) begin
      s_bits.push_back(1'b0);
      ones       = 0;
      last_stuff = 1;
    end
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int j = 0; j < 8; j++) push_bit(v[j]);
  endtask

  task automatic build_model(input logic [1:0] pkt, input int size);
    int         n;
    int         len;
    logic [15:0] crcf;
    logic       lvl;
    logic [1:0] per_bit[$];
    s_bits.delete();
    first_idx.delete();
    stuff_before.delete();
    bit_start.delete();
    exp_line.delete();
    ones       = 0;
    last_stuff = 0;
    push_byte(8'h80);
    case (pkt)
      2'b10:   push_byte(8'hD2);
      2'b11:   push_byte(8'h5A);
      default: push_byte(8'hC3);
    endcase
    if (pkt == 2'b01) begin
      n = (size > 64) ? 64 : size;
      for (int k = 0; k < n; k++) begin
        first_idx.push_back(s_bits.size());
        stuff_before.push_back(last_stuff);
        push_byte(pay[k]);
      end
      crcf = ~crc_of(n);
      for (int j = 15; j >= 0; j--) push_bit(crcf[j]);
    end
    lvl = 1'b1;
    foreach (s_bits[i]) begin
      if (!s_bits[i]) lvl = ~lvl;
      per_bit.push_back({lvl, ~lvl});
    end
    per_bit.push_back(2'b00);
    per_bit.push_back(2'b00);
    per_bit.push_back(2'b10);
    foreach (per_bit[i]) begin
      bit_start.push_back(exp_line.size());
      len = (i % 3 == 2) ? 9 : 8;
      repeat (len) exp_line.push_back(per_bit[i]);
    end
  endtask

  // Send one packet; abort_at >= 0 asserts reset after that many line clk
  task automatic run_packet(input logic [1:0] pkt, input int size, input int abort_at);
    int n;
    int limit;
    int k_pulse;
    int lo;
    int hi;
    int pulses[$];
    build_model(pkt, size);
    n       = (pkt == 2'b01) ? ((size > 64) ? 64 : size) : 0;
    limit   = (abort_at >= 0) ? abort_at : exp_line.size();
    k_pulse = 0;
    @(negedge clk);
    tx_packet           = pkt;
    tx_packet_data_size = 7'(size);
    @(posedge clk); #1;
    check("latch_cycle_J", {dPlus_out, dMinus_out}, 2'b10);
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      check($sformatf("line[%0d]", c), {dPlus_out, dMinus_out}, exp_line[c]);
      check($sformatf("done_low[%0d]", c), tx_done, 1'b0);
      if (get_tx_packet) begin
        pulses.push_back(c);
        if (k_pulse < n) tx_packet_data = pay[k_pulse];
        k_pulse++;
      end
    end
    if (abort_at >= 0) begin
      @(negedge clk);
      n_rst     = 1'b1;
      tx_packet = 2'b00;
      @(posedge clk); #1;
      check("abort_idle_J", {dPlus_out, dMinus_out, tx_done, get_tx_packet}, 4'b1000);
      @(negedge clk);
      n_rst = 1'b0;
    end else begin
      @(posedge clk); #1;
      check("done_pulse", {tx_done, dPlus_out, dMinus_out, get_tx_packet}, 4'b1100);
      tx_packet = 2'b00;
      check("get_count", pulses.size(), n);
      for (int k = 0; k < pulses.size() && k < n; k++) begin
        lo = bit_start[first_idx[k] - 1 - stuff_before[k]];
        hi = bit_start[first_idx[k]] - 1;
        check($sformatf("get_window[%0d]", k), (pulses[k] >= lo && pulses[k] <= hi), 1'b1);
      end
      @(posedge clk); #1;
      check("done_clear", {tx_done, dPlus_out, dMinus_out}, 3'b010);
    end
  endtask

  initial begin
    n_rst               = 1'b1;
    tx_packet           = 2'b00;
    tx_packet_data_size = 7'd0;
    tx_packet_data      = 8'h00;
    for (int k = 0; k < 64; k++) pay[k] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {dPlus_out, dMinus_out, tx_done, get_tx_packet}, 4'b1000);
    @(negedge clk);
    n_rst = 1'b0;

    // Idle line held with no request
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      check($sformatf("idle[%0d]", c), {dPlus_out, dMinus_out, tx_done, get_tx_packet}, 4'b1000);
    end

    // Hand-computed pins on the model
    pay[0] = 8'hFF;
    check("crc_pin_ff", crc_of(1), 16'hFF00);
    pay[0] = 8'h00;
    check("crc_pin_00", crc_of(1), 16'hFD02);
    build_model(2'b10, 0);
    check("model_ack_len", exp_line.size(), 158);
    check("model_first_K", exp_line[0], 2'b01);
    build_model(2'b01, 0);
    check("model_data0_len", exp_line.size(), 291);
    pay[0] = 8'hFF;
    build_model(2'b01, 1);
    check("model_ff_bits", s_bits.size(), 42);
    check("model_ff_len", exp_line.size(), 375);

    // ACK, NAK, empty DATA, single 0xFF byte
    run_packet(2'b10, 0, -1);
    run_packet(2'b11, 0, -1);
    run_packet(2'b01, 0, -1);
    pay[0] = 8'hFF;
    run_packet(2'b01, 1, -1);

    // Two bytes
    pay[0] = 8'h00;
    pay[1] = 8'h5A;
    run_packet(2'b01, 2, -1);

    // Oversized request clamps to 64 bytes
    for (int k = 0; k < 64; k++) pay[k] = (k % 2 == 1) ? 8'h5A : 8'h00;
    run_packet(2'b01, 100, -1);

    // Reset mid-payload, then a clean ACK
    pay[0] = 8'h12;
    pay[1] = 8'h34;
    pay[2] = 8'h56;
    run_packet(2'b01, 3, 200);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("post_abort_idle[%0d]", c), {dPlus_out, dMinus_out, tx_done, get_tx_packet}, 4'b1000);
    end
    run_packet(2'b10, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
